// File: rtl/vga_timing_rx.sv
// Recovers VGA pixel coordinates from hsync/vsync and tracks whether the
// incoming timing matches the configured mode.
//
// state  | meaning
// SEARCH | waiting for a vsync leading edge to start measuring
// CHECK  | measuring one frame; frame_good drops on any violation
// LOCKED | timing matches parameters; violations pulse err_out
module vga_timing_rx #(
  parameter int H_VIZ   = 640,
  parameter int H_PULSE = 96,
  parameter int H_BP    = 48,
  parameter int H_SYNC  = 800,
  parameter int V_VIZ   = 480,
  parameter int V_PULSE = 2,
  parameter int V_BP    = 33,
  parameter int V_SYNC  = 525
) (
  input  logic       clk_vga,
  input  logic       rst_vga,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       de_out,
  output logic       locked_out,
  output logic       frame_start_out,
  output logic       err_out,
  output logic [9:0] h_total_out,
  output logic [9:0] v_total_out
);

  localparam logic [9:0] H_ACT0 = 10'(H_PULSE + H_BP);
  localparam logic [9:0] H_ACT1 = 10'(H_PULSE + H_BP + H_VIZ);
  localparam logic [9:0] H_END  = 10'(H_SYNC);
  localparam logic [9:0] V_ACT0 = 10'(V_PULSE + V_BP);
  localparam logic [9:0] V_ACT1 = 10'(V_PULSE + V_BP + V_VIZ);
  localparam logic [9:0] V_END  = 10'(V_SYNC);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t     state;
  logic       frame_good;
  logic       hs_r, hs_p, vs_r, vs_p;
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       hs_fall, vs_fall;
  logic       h_len_bad, h_timeout, v_len_bad, v_misalign, viol;
  logic       h_in, v_in, de_nxt;

  assign hs_fall = hs_p & ~hs_r;
  assign vs_fall = vs_p & ~vs_r;
  assign h_nxt   = h_cnt + 10'd1;
  assign v_nxt   = v_cnt + 10'd1;

  // h_cnt passes through H_END only once on its way to saturation, so a
  // stuck sync raises the timeout for a single cycle.
  assign h_len_bad  = hs_fall && (h_nxt != H_END);
  assign h_timeout  = !hs_fall && (h_cnt == H_END);
  assign v_len_bad  = vs_fall && (v_nxt != V_END);
  assign v_misalign = vs_fall && !hs_fall;
  assign viol       = h_len_bad | h_timeout | v_len_bad | v_misalign;

  assign h_in   = (h_cnt >= H_ACT0) && (h_cnt < H_ACT1);
  assign v_in   = (v_cnt >= V_ACT0) && (v_cnt < V_ACT1);
  assign de_nxt = h_in & v_in;

  always_ff @(posedge clk_vga or posedge rst_vga) begin
    if (rst_vga) begin
      hs_r            <= 1'b1;
      hs_p            <= 1'b1;
      vs_r            <= 1'b1;
      vs_p            <= 1'b1;
      h_cnt           <= '0;
      v_cnt           <= '0;
      h_total_out     <= '0;
      v_total_out     <= '0;
      frame_start_out <= 1'b0;
      de_out          <= 1'b0;
      x_out           <= '0;
      y_out           <= '0;
      err_out         <= 1'b0;
      locked_out      <= 1'b0;
      frame_good      <= 1'b0;
      state           <= SEARCH;
    end else begin
      hs_r <= hsync_in;
      hs_p <= hs_r;
      vs_r <= vsync_in;
      vs_p <= vs_r;

      if (hs_fall) begin
        h_total_out <= h_nxt;
        h_cnt       <= '0;
      end else if (h_cnt != CNT_MAX) begin
        h_cnt <= h_nxt;
      end

      frame_start_out <= vs_fall & hs_fall;
      if (vs_fall) begin
        v_cnt <= '0;
        if (hs_fall) v_total_out <= v_nxt;
      end else if (hs_fall && (v_cnt != CNT_MAX)) begin
        v_cnt <= v_nxt;
      end

      de_out <= de_nxt;
      x_out  <= de_nxt ? (h_cnt - H_ACT0) : '0;
      y_out  <= de_nxt ? (v_cnt - V_ACT0) : '0;

      err_out <= (state == LOCKED) && viol;

      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state      <= CHECK;
            frame_good <= 1'b1;
          end
        end
        CHECK: begin
          if (vs_fall) begin
            if (frame_good && !viol) begin
              state      <= LOCKED;
              locked_out <= 1'b1;
            end else begin
              frame_good <= 1'b1;
            end
          end else if (viol) begin
            frame_good <= 1'b0;
          end
        end
        LOCKED: begin
          if (viol) begin
            state      <= SEARCH;
            locked_out <= 1'b0;
          end
        end
        default: begin
          state      <= SEARCH;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx using a scaled-down 8x4 mode (16 clocks x 9 lines)
// so several frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_rx;

  localparam int H_VIZ = 8, H_PULSE = 2, H_BP = 3, H_SYNC = 16;
  localparam int V_VIZ = 4, V_PULSE = 1, V_BP = 2, V_SYNC = 9;
  localparam int HA0 = H_PULSE + H_BP;
  localparam int VA0 = V_PULSE + V_BP;

  logic       clk_vga = 1'b0;
  logic       rst_vga = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] x_out, y_out, h_total_out, v_total_out;
  logic       de_out, locked_out, frame_start_out, err_out;

  always #5 clk_vga = ~clk_vga;

  vga_timing_rx #(
    .H_VIZ(H_VIZ), .H_PULSE(H_PULSE), .H_BP(H_BP), .H_SYNC(H_SYNC),
    .V_VIZ(V_VIZ), .V_PULSE(V_PULSE), .V_BP(V_BP), .V_SYNC(V_SYNC)
  ) dut (
    .clk_vga(clk_vga), .rst_vga(rst_vga),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x_out(x_out), .y_out(y_out), .de_out(de_out),
    .locked_out(locked_out), .frame_start_out(frame_start_out),
    .err_out(err_out), .h_total_out(h_total_out), .v_total_out(v_total_out)
  );

  typedef struct packed {
    logic       v;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  typedef struct {
    int   len;
    int   exp_err;
    logic exp_locked;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[4];

  int   checks = 0, failures = 0;
  int   tcount = 0, err_cnt = 0, fs_cnt = 0, de_cnt = 0;
  int   lock_rise = -100, vs_tick = 0, e0;
  bit   sb_en = 1'b0, de_cnt_en = 1'b0, de_seen = 1'b0;
  logic prev_locked = 1'b0;
  logic [9:0] de_fx, de_fy, de_lx, de_ly;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs for stimulus clock c of line l (c=0 is the first hsync-low clock).
  function automatic exp_t model(input int line, input int c);
    exp_t e;
    e.v  = sb_en;
    e.de = (c >= HA0) && (c < HA0 + H_VIZ) && (line >= VA0) && (line < VA0 + V_VIZ);
    e.x  = e.de ? 10'(c - HA0) : 10'd0;
    e.y  = e.de ? 10'(line - VA0) : 10'd0;
    return e;
  endfunction

  // One pixel clock; pixel outputs lag stimulus by two edges.
  task automatic tick(input logic hs, input logic vs, input int line, input int c);
    exp_t e;
    hsync_in = hs;
    vsync_in = vs;
    sb_q.push_back(model(line, c));
    tcount++;
    @(posedge clk_vga);
    @(negedge clk_vga);
    if (err_out) err_cnt++;
    if (frame_start_out) fs_cnt++;
    if (locked_out === 1'b1 && prev_locked !== 1'b1) lock_rise = tcount;
    prev_locked = locked_out;
    if (de_cnt_en && de_out) begin
      if (!de_seen) begin
        de_fx = x_out;
        de_fy = y_out;
      end
      de_seen = 1'b1;
      de_lx = x_out;
      de_ly = y_out;
      de_cnt++;
    end
    if (sb_q.size() > 2) begin
      e = sb_q.pop_front();
      if (e.v) check("sb_pixel", {11'd0, de_out, x_out, y_out}, {11'd0, e.de, e.x, e.y});
    end
  endtask

  task automatic run_line(input int line, input int len, input logic vs_low);
    if (line == 0 && vs_low) vs_tick = tcount + 1;
    for (int c = 0; c < len; c++)
      tick((c < H_PULSE) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1, line, c);
  endtask

  task automatic run_lines(input int first, input int last);
    for (int l = first; l <= last; l++) run_line(l, H_SYNC, l < V_PULSE);
  endtask

  // Second vs_fall of a clean stream: locked_out must rise one clock later.
  task automatic relock(input string name);
    run_lines(0, V_SYNC - 1);
    check({name, "_before_close"}, locked_out, 0);
    run_line(0, H_SYNC, 1'b1);
    check({name, "_rise"}, lock_rise - vs_tick, 1);
    run_lines(1, V_SYNC - 1);
  endtask

  initial begin
    vecs[0] = '{len: 16, exp_err: 0, exp_locked: 1'b1};
    vecs[1] = '{len: 15, exp_err: 1, exp_locked: 1'b0};
    vecs[2] = '{len: 17, exp_err: 1, exp_locked: 1'b0};
    vecs[3] = '{len: 16, exp_err: 0, exp_locked: 1'b1};

    @(negedge clk_vga);
    @(negedge clk_vga);
    check("reset_state", {de_out, x_out, y_out, locked_out, frame_start_out,
                          err_out, h_total_out, v_total_out}, 0);
    rst_vga = 1'b0;
    sb_en = 1'b1;

    // Nominal stream from reset.
    run_lines(0, V_SYNC - 1);
    run_line(0, H_SYNC, 1'b1);
    check("lock_after_2nd_vs", lock_rise - vs_tick, 1);
    run_lines(1, V_SYNC - 1);
    run_lines(0, V_SYNC - 1);
    check("h_total_nominal", h_total_out, H_SYNC);
    check("v_total_nominal", v_total_out, V_SYNC);
    check("frame_start_count", fs_cnt, 3);
    check("no_err_acquire", err_cnt, 0);
    check("locked_nominal", locked_out, 1);

    // Full locked frame of visible pixels.
    de_cnt_en = 1'b1;
    run_lines(0, V_SYNC - 1);
    de_cnt_en = 1'b0;
    check("de_count", de_cnt, H_VIZ * V_VIZ);
    check("first_pixel", {de_fx, de_fy}, 0);
    check("last_pixel", {de_lx, de_ly}, {10'(H_VIZ - 1), 10'(V_VIZ - 1)});

    // Line-length perturbations on a blanking line while locked.
    for (int i = 0; i < 4; i++) begin
      e0 = err_cnt;
      run_line(0, H_SYNC, 1'b1);
      run_line(1, vecs[i].len, 1'b0);
      run_line(2, H_SYNC, 1'b0);
      check("len_err_pulses", err_cnt - e0, vecs[i].exp_err);
      check("len_h_total", h_total_out, vecs[i].len);
      check("len_locked", locked_out, vecs[i].exp_locked);
      run_lines(3, V_SYNC - 1);
      if (!vecs[i].exp_locked) relock("len_relock");
    end

    // hsync stuck high long enough for h_cnt to saturate.
    e0 = err_cnt;
    run_lines(0, 2);
    for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 2, H_SYNC + i);
    check("timeout_err_once", err_cnt - e0, 1);
    check("timeout_unlocked", locked_out, 0);
    run_line(3, H_SYNC, 1'b0);
    // A saturated h_cnt of 1023 plus one wraps to 0 in the 10-bit total.
    check("h_cnt_saturated", h_total_out, 0);
    check("timeout_no_more_err", err_cnt - e0, 1);
    run_lines(4, V_SYNC - 1);
    relock("stall_relock");

    // vsync falling mid-line on a visible row.
    e0 = err_cnt;
    run_lines(0, 2);
    sb_en = 1'b0;
    for (int c = 0; c < H_SYNC; c++) begin
      tick((c < H_PULSE) ? 1'b0 : 1'b1, (c == 8 || c == 9) ? 1'b0 : 1'b1, 3, c);
      if (c == 10) check("midline_v_cleared", {de_out, x_out, y_out}, 0);
    end
    check("midline_err", err_cnt - e0, 1);
    check("midline_v_total", v_total_out, V_SYNC);
    check("midline_unlocked", locked_out, 0);
    run_lines(4, V_SYNC - 1);
    sb_en = 1'b1;
    relock("midline_relock");

    // Asynchronous reset in the middle of a visible line.
    run_lines(0, 3);
    for (int c = 0; c < 9; c++) tick((c < H_PULSE) ? 1'b0 : 1'b1, 1'b1, 4, c);
    check("pre_reset_de", {de_out, x_out, y_out}, {1'b1, 10'd1, 10'd1});
    #2 rst_vga = 1'b1;
    #1 check("async_reset", {de_out, x_out, y_out, locked_out, frame_start_out,
                             err_out, h_total_out, v_total_out}, 0);
    @(negedge clk_vga);
    @(negedge clk_vga);
    rst_vga = 1'b0;
    sb_q.delete();
    prev_locked = 1'b0;
    relock("reset_relock");
    check("reset_locked_final", locked_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_VIZ, 640, visible pixels per line
- H_PULSE, 96, hsync pulse clocks
- H_BP, 48, horizontal back porch
- H_SYNC, 800, clocks per line
- V_VIZ, 480, visible lines
- V_PULSE, 2, vsync pulse lines
- V_BP, 33, vertical back porch
- V_SYNC, 525, lines per frame

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_vga, in, 1, pixel clock
- rst_vga, in, 1, reset
- hsync_in, in, 1, active-low horizontal sync, synchronous to clk_vga
- vsync_in, in, 1, active-low vertical sync, synchronous to clk_vga
- x_out, out, 10, recovered visible column
- y_out, out, 10, recovered visible row
- de_out, out, 1, visible-pixel strobe
- locked_out, out, 1, timing matches parameters
- frame_start_out, out, 1, one-clock pulse at each vsync leading edge
- err_out, out, 1, one-clock pulse on timing violation while locked
- h_total_out, out, 10, last measured line length
- v_total_out, out, 10, last measured frame length

REQ-003 Reset is rst_vga, asynchronous, active-high; the clock is clk_vga.

Function
REQ-004 hsync_in and vsync_in SHALL each be registered once (hs_r, vs_r), then delayed once more (hs_p, vs_p).
REQ-005 Leading edges SHALL be decoded combinationally: hs_fall = hs_p & ~hs_r; vs_fall = vs_p & ~vs_r.
REQ-006 h_cnt (10 bit) SHALL update on every clock:
- on hs_fall: h_total_out <= h_cnt+1, then h_cnt <= 0
- otherwise: h_cnt increments, saturating at 1023
REQ-007 v_cnt (10 bit) SHALL increment on every hs_fall, saturating at 1023.
REQ-008 When vs_fall is coincident with hs_fall, the block SHALL load v_total_out <= v_cnt+1, clear v_cnt to 0, and pulse frame_start_out for one clock.
REQ-009 When vs_fall is not coincident with hs_fall, the block SHALL clear v_cnt to 0, leave v_total_out unchanged, and treat the event as a violation (REQ-014).
REQ-010 de_out SHALL be registered and high iff both hold:
- H_PULSE+H_BP <= h_cnt < H_PULSE+H_BP+H_VIZ
- V_PULSE+V_BP <= v_cnt < V_PULSE+V_BP+V_VIZ
REQ-011 Coordinate outputs SHALL be registered alongside de_out:
- while de is true: x_out = h_cnt-(H_PULSE+H_BP) and y_out = v_cnt-(V_PULSE+V_BP)
- while de is false: both outputs SHALL be 0
REQ-012 de_out SHALL be independent of locked_out; downstream logic qualifies data with locked_out.
REQ-013 Latency: de_out SHALL rise exactly H_PULSE+H_BP+2 clock edges after the edge that first samples hsync_in low on a visible line (146 with defaults).
REQ-014 A violation SHALL be any one of:
- hs_fall with h_cnt+1 != H_SYNC
- h_cnt reaching H_SYNC with no hs_fall (timeout; sync stuck)
- vs_fall with v_cnt+1 != V_SYNC
- vs_fall not coincident with hs_fall
REQ-015 The lock FSM SHALL have states SEARCH, CHECK and LOCKED, with these transitions:
- SEARCH -> CHECK on the first vs_fall
- CHECK: on a violation, clear the frame-good flag and stay in CHECK
- CHECK -> LOCKED on a vs_fall that closes a frame with no violation
- CHECK, violation on the closing vs_fall itself: stay in CHECK and restart the check
- LOCKED -> SEARCH on any violation
REQ-016 In LOCKED, a violation SHALL pulse err_out for exactly one clock in the cycle after detection; it SHALL NOT pulse in SEARCH or CHECK.
REQ-017 locked_out SHALL be registered and equal (state == LOCKED).
REQ-018 Simultaneous violation and frame close SHALL resolve as a violation.
REQ-019 Timeout SHALL be flagged once per stall, not every clock, while h_cnt stays saturated.

Reset
REQ-020 While rst_vga is high, every output and internal register SHALL be 0, the FSM SHALL be in SEARCH, and hs_r/hs_p/vs_r/vs_p SHALL be 1 (idle-high).
REQ-021 A reset asserted mid-frame SHALL take effect immediately and asynchronously.
REQ-022 After reset, locked_out SHALL remain 0 until one full violation-free frame has been observed.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Nominal 640x480@800x525 stream for 3 frames -> locked_out rises 1 clock after the 2nd vs_fall; h_total_out=800, v_total_out=525; frame_start_out pulses once per frame.
- Locked nominal frame -> exactly 307200 de_out cycles; x_out spans 0..639 and y_out spans 0..479; first de_out pixel is (0,0), last is (639,479).
- Locked; one line shortened to 799 clocks -> single err_out pulse; locked_out=0; h_total_out=799; locked_out regained after 2 further clean vs_fall events.
- Locked; hsync_in held high -> err_out pulses once when h_cnt reaches 800; h_cnt saturates at 1023; no further err_out.
- Locked; vsync_in falls mid-line at h_cnt=400 -> err_out pulse; v_cnt=0; v_total_out unchanged.
- rst_vga pulsed at line 200 -> all outputs 0 asynchronously; relock after 2 vs_fall events of clean timing.
